misr_bist_unit: RTL and testbench
=================================

# misr_bist_unit

Parametrised multiple-input signature register (MISR) with a built-in session controller. It compacts NIN-bit response words from a block under test into an NBIT-bit signature using a programmable Galois feedback polynomial. It counts NPAT valid patterns, then compares the final signature against a golden value and reports pass/fail. It sits at the output of a BIST-wrapped block and supports scan-out of the signature over a serial chain, replacing the fixed 8-bit, 4-input compactor.

## Interface
- NBIT, 16: signature width; must be ≥ 2.
- NIN, 4: response input width; 1 ≤ NIN ≤ NBIT.
- POLY, 16'h1021: feedback taps; bit i = 1 XORs the MSB into stage i. POLY[0] must be 1.
- SEED, all ones: signature value loaded on reset and on start.
- NPAT, 256: valid patterns per session; must be ≥ 1.
- CW, $clog2(NPAT+1): pattern counter width.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- start, input, 1: begin session; single-cycle pulse.
- din, input, NIN: response word to compact.
- din_valid, input, 1: din is consumed this cycle (RUN state only).
- golden, input, NBIT: expected signature; must be stable from start until done.
- shift_en, input, 1: serial shift of the signature (IDLE/DONE only).
- scan_in, input, 1: serial input to stage 0 during shift.
- scan_out, output, 1: always equals signature[NBIT-1].
- signature, output, NBIT: current register contents.
- pat_cnt, output, CW: valid patterns consumed in the current session.
- busy, output, 1: high in RUN.
- done, output, 1: high in DONE.
- pass, output, 1: registered compare result; meaningful only while done = 1.

## Operation
- States: IDLE, RUN, DONE. Reset drives IDLE, signature = SEED, pat_cnt = 0, busy = 0, done = 0, pass = 0.
- Compaction step (RUN, din_valid = 1):
  - next[i] = (i > 0 ? sig[i-1] : 0) ^ (POLY[i] & sig[NBIT-1]) ^ (i < NIN ? din[i] : 0).
  - pat_cnt increments.
- RUN, din_valid = 0: signature and pat_cnt hold. Gaps are unlimited.
- start in any state (reset excluded):
  - signature = SEED, pat_cnt = 0, done = 0, pass = 0, then RUN.
  - start in RUN restarts the session.
  - start dominates shift_en and din_valid in the same cycle.
- RUN → DONE on the edge that consumes the valid pattern with pat_cnt == NPAT-1:
  - That edge writes the final signature.
  - pass <= (next signature == golden).
  - pat_cnt = NPAT.
- DONE holds signature, pass, and pat_cnt until start or rst.
- Shift (shift_en = 1 in IDLE or DONE): signature <= {signature[NBIT-2:0], scan_in}.
  - MSB leaves first on scan_out.
  - pass and done are unchanged.
  - shift_en is ignored in RUN.
- din and din_valid are ignored outside RUN.
- rst dominates all inputs, including mid-session and mid-shift.

## Timing
- First compaction occurs on the first edge after the start edge on which din_valid = 1. The start edge itself does not compact.
- done and pass are valid in the cycle immediately after the final valid pattern edge, with zero extra latency.
- busy falls and done rises on the same edge.
- scan_out is combinational from the register and changes only on clock edges.
- A full signature unload takes NBIT cycles of shift_en.
- pat_cnt never wraps: it saturates at NPAT in DONE.

## Test plan
All scenarios use NBIT=8, NIN=4, POLY=8'h1D, SEED=8'hFF, NPAT=4 unless noted.

1. Reset, then start, then 4 cycles of din_valid = 1 with din = 4'h0 and golden = 8'h4B:
   - Signature steps FF → E3 → DB → AB → 4B.
   - done = 1 and pass = 1 one cycle after the 4th valid.
   - busy = 0, pat_cnt = 4.
2. Same stimulus with din_valid gaps of 0, 3, and 1 cycles between patterns:
   - Final signature is still 8'h4B with pass = 1.
   - signature and pat_cnt hold during gaps.
3. Same stimulus with golden = 8'h4A:
   - done = 1, pass = 0, signature = 8'h4B.
4. After scenario 1, shift_en high for 8 cycles with scan_in = 1:
   - scan_out sequence is 0,1,0,0,1,0,1,1 (MSB first).
   - Final signature = 8'hFF; done and pass stay 1.
5. Reset mid-session: assert rst after 2 valid patterns:
   - Next cycle: IDLE, signature = FF, pat_cnt = 0, busy = 0, done = 0, pass = 0.
   - A subsequent full session still yields 8'h4B.
6. Conflicting controls:
   - start after 2 patterns restarts the session: pat_cnt = 0, signature = FF, and 4 further patterns are required.
   - shift_en in RUN has no effect.
   - start and shift_en together in DONE: start wins.

Source files
------------

// File: rtl/misr_bist_unit.sv
// misr_bist_unit: multiple-input signature register with a session controller.
// Compacts NIN-bit response words into an NBIT-bit Galois signature. After NPAT
// valid patterns it compares the signature with a golden value. The signature
// can be unloaded serially (MSB first) while the unit is idle or done.
module misr_bist_unit #(
  parameter int              NBIT = 16,
  parameter int              NIN  = 4,
  parameter logic [NBIT-1:0] POLY = 16'h1021,
  parameter logic [NBIT-1:0] SEED = '1,
  parameter int              NPAT = 256,
  parameter int              CW   = $clog2(NPAT+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NIN-1:0]  din,
  input  logic            din_valid,
  input  logic [NBIT-1:0] golden,
  input  logic            shift_en,
  input  logic            scan_in,
  output logic            scan_out,
  output logic [NBIT-1:0] signature,
  output logic [CW-1:0]   pat_cnt,
  output logic            busy,
  output logic            done,
  output logic            pass
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [NBIT-1:0] din_ext;
  logic [NBIT-1:0] sig_nxt;

  // Zero-extend the response word so it lines up with stages 0..NIN-1.
  always_comb begin
    din_ext          = '0;
    din_ext[NIN-1:0] = din;
  end

  // One Galois compaction step: shift up, fold the MSB into the tap stages,
  // and mix in the response word.
  always_comb begin
    sig_nxt = {signature[NBIT-2:0], 1'b0}
            ^ (POLY & {NBIT{signature[NBIT-1]}})
            ^ din_ext;
  end

  assign scan_out = signature[NBIT-1];

  // Session controller. start beats every other control except rst; the
  // final valid pattern writes the signature and the compare result together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      signature <= SEED;
      pat_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (start) begin
      state     <= RUN;
      signature <= SEED;
      pat_cnt   <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (din_valid) begin
            signature <= sig_nxt;
            pat_cnt   <= pat_cnt + CW'(1);
            if (pat_cnt == CW'(NPAT-1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_nxt == golden);
            end
          end
        end
        IDLE, DONE: begin
          if (shift_en)
            signature <= {signature[NBIT-2:0], scan_in};
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_misr_bist_unit.sv
// tb_misr_bist_unit: directed scenarios plus randomized sessions, each cycle
// compared against an arithmetic reference model of the compactor.
module tb_misr_bist_unit;
  localparam int        NBIT = 8;
  localparam int        NIN  = 4;
  localparam int        NPAT = 4;
  localparam int        CW   = $clog2(NPAT+1);
  localparam logic [7:0] POLY = 8'h1D;
  localparam logic [7:0] SEED = 8'hFF;

  logic            clk = 1'b0;
  logic            rst, start, din_valid, shift_en, scan_in;
  logic [NIN-1:0]  din;
  logic [NBIT-1:0] golden;
  logic            scan_out, busy, done, pass;
  logic [NBIT-1:0] signature;
  logic [CW-1:0]   pat_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  int msig, mcnt;
  bit mbusy, mdone, mpass;

  misr_bist_unit #(.NBIT(NBIT), .NIN(NIN), .POLY(POLY), .SEED(SEED), .NPAT(NPAT)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .golden(golden), .shift_en(shift_en), .scan_in(scan_in), .scan_out(scan_out),
    .signature(signature), .pat_cnt(pat_cnt), .busy(busy), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  // Signature as polynomial arithmetic: multiply by x mod POLY, add the word.
  function automatic int step_sig(input int s, input int d);
    int t;
    t = s << 1;
    if (t >= 256) t = t ^ (256 | int'(POLY));
    return (t ^ d) & 'hFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit s, input bit dv, input int d,
                       input bit sh, input bit si);
    if (r) begin
      msig = SEED; mcnt = 0; mbusy = 0; mdone = 0; mpass = 0;
    end else if (s) begin
      msig = SEED; mcnt = 0; mbusy = 1; mdone = 0; mpass = 0;
    end else if (mbusy) begin
      if (dv) begin
        msig = step_sig(msig, d);
        mcnt++;
        if (mcnt == NPAT) begin
          mbusy = 0; mdone = 1; mpass = (msig == int'(golden));
        end
      end
    end else if (sh) begin
      msig = ((msig << 1) | int'(si)) & 'hFF;
    end
  endtask

  // One clock: drive, advance the model, clock, then compare everything.
  task automatic cyc(input bit r, input bit s, input bit dv, input logic [3:0] d,
                     input bit sh, input bit si);
    rst = r; start = s; din_valid = dv; din = d; shift_en = sh; scan_in = si;
    model(r, s, dv, int'(d), sh, si);
    @(posedge clk); #1;
    rst = 0; start = 0; din_valid = 0; shift_en = 0;
    chk("sig",      32'(signature), 32'(msig));
    chk("cnt",      32'(pat_cnt),   32'(mcnt));
    chk("busy",     32'(busy),      32'(mbusy));
    chk("done",     32'(done),      32'(mdone));
    chk("pass",     32'(pass),      32'(mpass));
    chk("scan_out", 32'(scan_out),  32'((msig >> 7) & 1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 4'($urandom), 0, 0);
  endtask

  logic [7:0] seq;
  logic [3:0] pats [NPAT];
  int         expsig;
  bit         good;

  initial begin
    rst = 1; start = 0; din_valid = 0; din = '0; shift_en = 0; scan_in = 0;
    golden = 8'h4B;
    msig = 0; mcnt = 0; mbusy = 0; mdone = 0; mpass = 0;

    // 1: reset, then a zero-input session
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_sig", 32'(signature), 32'hFF);
    chk("rst_flags", 32'({busy, done, pass, pat_cnt}), 32'h0);
    cyc(0, 1, 1, 4'hF, 1, 0);                 // start edge must not compact
    chk("start_sig", 32'(signature), 32'hFF);
    chk("start_busy", 32'(busy), 32'h1);
    seq = 8'hE3; cyc(0, 0, 1, 0, 0, 0); chk("step1", 32'(signature), 32'(seq));
    seq = 8'hDB; cyc(0, 0, 1, 0, 0, 0); chk("step2", 32'(signature), 32'(seq));
    seq = 8'hAB; cyc(0, 0, 1, 0, 0, 0); chk("step3", 32'(signature), 32'(seq));
    chk("not_done", 32'(done), 32'h0);
    seq = 8'h4B; cyc(0, 0, 1, 0, 0, 0); chk("step4", 32'(signature), 32'(seq));
    chk("s1_flags", 32'({busy, done, pass}), 32'b011);
    chk("s1_cnt", 32'(pat_cnt), 32'd4);
    cyc(0, 0, 1, 4'h5, 0, 0);                 // din ignored in DONE
    chk("done_hold", 32'(signature), 32'h4B);

    // 4: unload MSB first with scan_in = 1
    seq = 8'h4B;
    for (int k = 7; k >= 0; k--) begin
      chk("scan_seq", 32'(scan_out), 32'(seq[k]));
      cyc(0, 0, 0, 0, 1, 1);
    end
    chk("unload_sig", 32'(signature), 32'hFF);
    chk("unload_flags", 32'({done, pass}), 32'b11);

    // 2: gaps of 0, 3, 1 cycles between patterns
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 4'h7, 1, 1); cyc(0, 0, 0, 4'h3, 0, 0); cyc(0, 0, 0, 4'h1, 1, 0);
    chk("gap_hold_sig", 32'(signature), 32'hDB);
    chk("gap_hold_cnt", 32'(pat_cnt), 32'd2);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 4'h9, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("gap_final", 32'(signature), 32'h4B);
    chk("gap_pass", 32'(pass), 32'h1);

    // 3: wrong golden
    golden = 8'h4A;
    cyc(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < NPAT; k++) cyc(0, 0, 1, 0, 0, 0);
    chk("bad_gold", 32'({done, pass, signature}), 32'h24B);

    // 5: reset mid-session, then a clean session
    golden = 8'h4B;
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 1);                    // rst beats start too
    chk("mid_rst", 32'({busy, done, pass, pat_cnt, signature}), 32'h0FF);
    cyc(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < NPAT; k++) cyc(0, 0, 1, 0, 0, 0);
    chk("post_rst", 32'({done, pass, signature}), 32'h34B);

    // 6: restart in RUN, shift in RUN, start+shift in DONE
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 4'hA, 1, 1);
    chk("restart", 32'({pat_cnt, signature}), 32'h0FF);
    cyc(0, 0, 0, 0, 1, 0);
    chk("run_shift", 32'(signature), 32'hFF);
    for (int k = 0; k < NPAT-1; k++) cyc(0, 0, 1, 0, 0, 0);
    chk("restart_need4", 32'(done), 32'h0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("restart_done", 32'({done, signature}), 32'h14B);
    cyc(0, 1, 0, 0, 1, 0);
    chk("start_vs_shift", 32'({busy, done, pass, signature}), 32'h4FF);

    // randomized sessions with gaps and ignored noise
    for (int n = 0; n < 30; n++) begin
      expsig = SEED;
      for (int k = 0; k < NPAT; k++) begin
        pats[k] = 4'($urandom);
        expsig  = step_sig(expsig, int'(pats[k]));
      end
      good   = bit'($urandom_range(0, 1));
      golden = good ? 8'(expsig) : 8'(expsig ^ (1 << $urandom_range(0, 7)));
      idle($urandom_range(0, 2));
      cyc(0, 1, 0, 0, 0, 0);
      for (int k = 0; k < NPAT; k++) begin
        for (int g = $urandom_range(0, 3); g > 0; g--)
          cyc(0, 0, 0, 4'($urandom), bit'($urandom), bit'($urandom));
        cyc(0, 0, 1, pats[k], bit'($urandom), bit'($urandom));
      end
      chk("rand_sig", 32'(signature), 32'(expsig));
      chk("rand_pass", 32'({done, pass}), 32'({1'b1, good}));
      for (int k = 0; k < $urandom_range(0, 8); k++)
        cyc(0, 0, bit'($urandom), 4'($urandom), 1, bit'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
